// File: rtl/jtcop_objdma.sv
// Object DMA: on a dm_cs write, take the 68000 bus and copy LEN words of object RAM
// into the sprite buffer. Optional completion interrupt under JTCOP_OBJDMA_IRQ_EN.
module jtcop_objdma #(
    parameter int unsigned LEN = 1024,
    parameter int unsigned AW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_trig,
    input  logic          ASn,
    input  logic          BGn,
    output logic          BRn,
    output logic          BGACKn,
    output logic          ram_cs,
    output logic [AW-1:0] ram_addr,
    input  logic [15:0]   ram_data,
    input  logic          ram_ok,
    output logic          buf_we,
    output logic [AW-1:0] buf_addr,
    output logic [15:0]   buf_din,
    output logic          busy,
    output logic          done_irq,
    input  logic          irq_clr
);

    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] LAST = AW'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RD,
        S_WR,
        S_REL
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            pending_q, pending_d;
    logic            brn_q, brn_d;
    logic            bgackn_q, bgackn_d;
    logic            ram_cs_q, ram_cs_d;
    logic            buf_we_q, buf_we_d;
    logic            busy_q, busy_d;
    logic            irq_q, irq_d;

    // Sequencer and registered bus/strobe outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        pending_d = pending_q;

        unique case (state_q)
            S_IDLE: begin
                if (dma_trig) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (dma_trig) pending_d = 1'b1;
                if (!BGn && ASn) state_d = S_ACK;
            end
            S_ACK: begin
                if (dma_trig) pending_d = 1'b1;
                state_d = S_RD;
            end
            S_RD: begin
                if (dma_trig) pending_d = 1'b1;
                if (ram_ok) begin
                    data_d  = ram_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (dma_trig) pending_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_REL;
                end else begin
                    cnt_d   = cnt_q + AW'(1);
                    state_d = S_RD;
                end
            end
            S_REL: begin
                // A trigger landing here merges with any pending one
                pending_d = 1'b0;
                if (pending_q || dma_trig) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        brn_d    = (state_d != S_REQ);
        bgackn_d = !((state_d == S_ACK) || (state_d == S_RD) || (state_d == S_WR));
        ram_cs_d = (state_d == S_RD);
        buf_we_d = (state_d == S_WR);
        busy_d   = (state_d == S_REQ) || (state_d == S_ACK) ||
                   (state_d == S_RD)  || (state_d == S_WR);

`ifdef JTCOP_OBJDMA_IRQ_EN
        irq_d = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (state_d == S_REL) irq_d = 1'b1;
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            pending_q <= 1'b0;
            brn_q     <= 1'b1;
            bgackn_q  <= 1'b1;
            ram_cs_q  <= 1'b0;
            buf_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            brn_q     <= brn_d;
            bgackn_q  <= bgackn_d;
            ram_cs_q  <= ram_cs_d;
            buf_we_q  <= buf_we_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

`ifndef JTCOP_OBJDMA_IRQ_EN
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
`endif

    // Counter stays put through WR, so it serves both read and write addresses
    assign BRn      = brn_q;
    assign BGACKn   = bgackn_q;
    assign ram_cs   = ram_cs_q;
    assign ram_addr = cnt_q;
    assign buf_we   = buf_we_q;
    assign buf_addr = cnt_q;
    assign buf_din  = data_q;
    assign busy     = busy_q;
    assign done_irq = irq_q;

endmodule

// File: tb/tb_jtcop_objdma.sv
// Directed bench for jtcop_objdma: bus handshake, full copy, ASn hold-off,
// pending merge, mid-transfer reset and the optional done interrupt.
module tb_jtcop_objdma;

    localparam int unsigned LEN = 1024;
    localparam int unsigned AW  = 10;
`ifdef JTCOP_OBJDMA_IRQ_EN
    localparam int IRQ_ON = 1;
`else
    localparam int IRQ_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dma_trig = 1'b0;
    logic          ASn = 1'b1;
    logic          BGn = 1'b1;
    logic          BRn, BGACKn, ram_cs, buf_we, busy, done_irq;
    logic [AW-1:0] ram_addr, buf_addr;
    logic [15:0]   ram_data = '0;
    logic          ram_ok = 1'b0;
    logic [15:0]   buf_din;
    logic          irq_clr = 1'b0;

    logic [15:0]   mem [0:LEN-1];
    int            errors = 0;
    int            checks = 0;

    int            we_cnt, addr_err, data_err, cs_err;
    logic [AW-1:0] exp_addr;
    logic          mon_clr = 1'b0;

    jtcop_objdma #(.LEN(LEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .dma_trig(dma_trig), .ASn(ASn), .BGn(BGn),
        .BRn(BRn), .BGACKn(BGACKn), .ram_cs(ram_cs), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_ok(ram_ok), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_din(buf_din), .busy(busy), .done_irq(done_irq), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    // RAM port: data valid one cycle after the request is seen
    always @(posedge clk) begin
        ram_ok   <= ram_cs && !ram_ok;
        ram_data <= mem[ram_addr];
    end

    // Buffer write monitor
    always @(negedge clk) begin
        if (mon_clr) begin
            we_cnt = 0; addr_err = 0; data_err = 0; cs_err = 0; exp_addr = '0;
        end else begin
            if (buf_we) begin
                if (buf_addr != exp_addr) addr_err++;
                if (buf_din != mem[buf_addr]) data_err++;
                exp_addr = exp_addr + AW'(1);
                we_cnt++;
            end
            if (ram_cs && BGACKn) cs_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_trig();
        dma_trig = 1'b1;
        tick();
        dma_trig = 1'b0;
    endtask

    task automatic wait_we(input int target, input int max);
        int n = 0;
        while (we_cnt < target && n < max) begin
            tick();
            n++;
        end
        if (n >= max) check("wait_we_timeout", 32'(we_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        if (n >= max) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < int'(LEN); i++) mem[i] = 16'hA500 + 16'(i);
        mon_clr = 1'b1;
        tick();
        tick();
        check("rst_BRn",    32'(BRn),      32'd1);
        check("rst_BGACKn", 32'(BGACKn),   32'd1);
        check("rst_ram_cs", 32'(ram_cs),   32'd0);
        check("rst_buf_we", 32'(buf_we),   32'd0);
        check("rst_busy",   32'(busy),     32'd0);
        check("rst_irq",    32'(done_irq), 32'd0);
        rst = 1'b0;
        mon_clr = 1'b0;
        tick();

        // Basic transfer with late grant
        pulse_trig();
        check("t1_BRn_low",   32'(BRn),    32'd0);
        check("t1_busy",      32'(busy),   32'd1);
        check("t1_BGACKn_hi", 32'(BGACKn), 32'd1);
        tick();
        tick();
        check("t1_BRn_held",  32'(BRn),    32'd0);
        BGn = 1'b0;
        ASn = 1'b1;
        tick();
        check("t1_BGACKn_low", 32'(BGACKn), 32'd0);
        check("t1_BRn_rel",    32'(BRn),    32'd1);
        tick();
        check("t1_rd_cs",   32'(ram_cs),   32'd1);
        check("t1_rd_addr", 32'(ram_addr), 32'd0);
        wait_idle(5000);
        check("t1_we_cnt",    32'(we_cnt),   32'd1024);
        check("t1_addr_err",  32'(addr_err), 32'd0);
        check("t2_data_err",  32'(data_err), 32'd0);
        check("t1_cs_err",    32'(cs_err),   32'd0);
        check("t1_BGACKn_end", 32'(BGACKn),  32'd1);
        check("t6_irq_set",   32'(done_irq), 32'(IRQ_ON));
        BGn = 1'b1;
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t6_irq_clr", 32'(done_irq), 32'd0);

        // Grant with ASn still active must not start the cycle
        clear_mon();
        pulse_trig();
        BGn = 1'b0;
        ASn = 1'b0;
        repeat (5) tick();
        check("t3_BGACKn_hold", 32'(BGACKn), 32'd1);
        check("t3_no_cs",       32'(ram_cs), 32'd0);
        check("t3_BRn_hold",    32'(BRn),    32'd0);
        ASn = 1'b1;
        tick();
        check("t3_BGACKn_low", 32'(BGACKn), 32'd0);
        wait_we(1024, 4000);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t6_irq_set_wins", 32'(done_irq), 32'(IRQ_ON));
        check("t3_rel_busy",     32'(busy),     32'd0);
        tick();
        check("t6_irq_stays", 32'(done_irq), 32'(IRQ_ON));
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("t6_irq_clr2",   32'(done_irq), 32'd0);
        check("t3_we_cnt",     32'(we_cnt),   32'd1024);
        check("t3_cs_err",     32'(cs_err),   32'd0);

        // Triggers during the transfer and in REL merge into one extra transfer
        clear_mon();
        pulse_trig();
        wait_we(100, 1000);
        pulse_trig();
        wait_we(500, 2000);
        pulse_trig();
        wait_idle(5000);
        check("t4_first_cnt", 32'(we_cnt), 32'd1024);
        pulse_trig();
        check("t4_restart_busy", 32'(busy), 32'd1);
        wait_we(2048, 4000);
        tick();
        wait_idle(100);
        repeat (6) tick();
        check("t4_no_third",  32'(busy),     32'd0);
        check("t4_we_cnt",    32'(we_cnt),   32'd2048);
        check("t4_addr_err",  32'(addr_err), 32'd0);
        check("t4_data_err",  32'(data_err), 32'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;

        // Reset mid-transfer aborts, next trigger starts at word 0
        clear_mon();
        pulse_trig();
        wait_we(300, 1500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_BRn",    32'(BRn),      32'd1);
        check("t5_BGACKn", 32'(BGACKn),   32'd1);
        check("t5_ram_cs", 32'(ram_cs),   32'd0);
        check("t5_busy",   32'(busy),     32'd0);
        check("t5_irq",    32'(done_irq), 32'd0);
        tick();
        check("t5_stays_idle", 32'(busy), 32'd0);
        clear_mon();
        pulse_trig();
        wait_we(1024, 4000);
        wait_idle(100);
        check("t5_we_cnt",   32'(we_cnt),   32'd1024);
        check("t5_addr_err", 32'(addr_err), 32'd0);
        check("t5_data_err", 32'(data_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
